l2_data_array_nway: RTL and testbench

L2_DATA_ARRAY_NWAY -- requirements
Module: l2_data_array_nway

---
 rtl/l2_data_array_nway_pkg.sv | 15 +
 rtl/l2_data_array_nway_if.sv | 33 +++
 rtl/l2_data_way.sv | 38 +++
 rtl/l2_data_array_nway.sv | 112 +++++++++++
 tb/tb_l2_data_array_nway.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_data_array_nway_pkg.sv
// Shared types and default geometry for the N-way L2 data array.
package l2_pkg;

    typedef enum logic {INIT, IDLE} l2_state_t;

    localparam int unsigned default_s_offset = 5;
    localparam int unsigned default_s_index  = 3;
    localparam int unsigned default_num_ways = 2;

    // Way-select width; a single way still needs a 1-bit port.
    function automatic int unsigned way_bits(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_data_array_nway_if.sv
// Request/response bus of the L2 data array; master drives requests, slave answers.
interface l2_data_array_nway_if
    import l2_pkg::*;
#(
    parameter int unsigned s_offset = default_s_offset,
    parameter int unsigned s_index  = default_s_index,
    parameter int unsigned num_ways = default_num_ways
);
    localparam int unsigned s_way  = way_bits(num_ways);
    localparam int unsigned s_mask = 1 << s_offset;
    localparam int unsigned s_line = 8 * s_mask;

    logic              read;
    logic              write;
    logic [s_way-1:0]  way;
    logic [s_index-1:0] index;
    logic [s_mask-1:0] write_en;
    logic [s_line-1:0] datain;
    logic [s_line-1:0] dataout;
    logic              resp;
    logic              ready;

    modport master (
        output read, write, way, index, write_en, datain,
        input  dataout, resp, ready
    );

    modport slave (
        input  read, write, way, index, write_en, datain,
        output dataout, resp, ready
    );

endinterface

// File: rtl/l2_data_way.sv
// One way of the data array: byte-masked synchronous write, asynchronous read, set clear.
module l2_data_way
    import l2_pkg::*;
#(
    parameter int unsigned s_offset = default_s_offset,
    parameter int unsigned s_index  = default_s_index,
    localparam int unsigned s_mask  = 1 << s_offset,
    localparam int unsigned s_line  = 8 * s_mask,
    localparam int unsigned num_sets = 1 << s_index
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [s_index-1:0] clear_index,
    input  logic               write,
    input  logic [s_index-1:0] index,
    input  logic [s_mask-1:0]  write_en,
    input  logic [s_line-1:0]  datain,
    output logic [s_line-1:0]  dataout
);

    (* ramstyle = "logic" *) logic [s_line-1:0] data [num_sets];

    // Clear has priority; the top never issues both in the same cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            data[clear_index] <= '0;
        end else if (write) begin
            for (int unsigned b = 0; b < s_mask; b++) begin
                if (write_en[b]) begin
                    data[index][8*b +: 8] <= datain[8*b +: 8];
                end
            end
        end
    end

    assign dataout = data[index];

endmodule

// File: rtl/l2_data_array_nway.sv
// N-way L2 data array: per-way storage, init clear sweep, write-first registered read.
module l2_data_array_nway
    import l2_pkg::*;
#(
    parameter int unsigned s_offset = default_s_offset,
    parameter int unsigned s_index  = default_s_index,
    parameter int unsigned num_ways = default_num_ways
) (
    input logic                 clk,
    input logic                 rst,
    l2_data_array_nway_if.slave bus
);

    localparam int unsigned s_mask   = 1 << s_offset;
    localparam int unsigned s_line   = 8 * s_mask;
    localparam int unsigned num_sets = 1 << s_index;

    l2_state_t          state;
    logic [s_index-1:0] counter;
    logic               init_done;
    logic               rvalid;
    logic [s_line-1:0]  rdata;

    logic [s_line-1:0]   way_data [num_ways];
    logic [num_ways-1:0] way_write;
    logic                clear;
    logic                way_valid;
    logic                accept_read;
    logic                accept_write;
    logic [s_line-1:0]   stored;
    logic [s_line-1:0]   forwarded;

    assign clear = (state == INIT) && !rst;

    // Out-of-range ways select nothing: writes drop and reads return zero.
    always_comb begin
        way_valid = 1'b0;
        stored    = '0;
        way_write = '0;
        for (int unsigned w = 0; w < num_ways; w++) begin
            if (32'(bus.way) == w) begin
                way_valid = 1'b1;
                stored    = way_data[w];
            end
        end
        accept_read  = (state == IDLE) && bus.read;
        accept_write = (state == IDLE) && bus.write && way_valid;
        for (int unsigned w = 0; w < num_ways; w++) begin
            way_write[w] = accept_write && (32'(bus.way) == w);
        end
        forwarded = stored;
        if (accept_write) begin
            for (int unsigned b = 0; b < s_mask; b++) begin
                if (bus.write_en[b]) begin
                    forwarded[8*b +: 8] = bus.datain[8*b +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < num_ways; g++) begin : gen_way
        l2_data_way #(
            .s_offset (s_offset),
            .s_index  (s_index)
        ) u_way (
            .clk         (clk),
            .clear       (clear),
            .clear_index (counter),
            .write       (way_write[g]),
            .index       (bus.index),
            .write_en    (bus.write_en),
            .datain      (bus.datain),
            .dataout     (way_data[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            counter   <= '0;
            init_done <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    rvalid  <= 1'b0;
                    counter <= counter + 1'b1;
                    if (counter == s_index'(num_sets - 1)) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                        counter   <= '0;
                    end
                end
                IDLE: begin
                    rvalid <= accept_read;
                    if (accept_read) begin
                        rdata <= forwarded;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign bus.dataout = rdata;
    assign bus.resp    = rvalid;
    assign bus.ready   = init_done;

endmodule

// File: tb/tb_l2_data_array_nway.sv
// Randomized self-checking bench for l2_data_array_nway against a byte-level array model.
module tb_l2_data_array_nway;
    import l2_pkg::*;

    localparam int unsigned s_offset = 5;
    localparam int unsigned s_index  = 3;
    localparam int unsigned num_ways = 2;
    localparam int unsigned num_sets = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_data_array_nway_if #(
        .s_offset (s_offset),
        .s_index  (s_index),
        .num_ways (num_ways)
    ) bus ();

    l2_data_array_nway #(
        .s_offset (s_offset),
        .s_index  (s_index),
        .num_ways (num_ways)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: bytes per (way, set), cleared by every init sweep.
    logic [7:0]   model [num_ways][num_sets][32];
    logic [255:0] last_dout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        bus.way      = '0;
        bus.index    = '0;
        bus.write_en = '0;
        bus.datain   = '0;
    endtask

    task automatic model_clear();
        for (int w = 0; w < num_ways; w++)
            for (int s = 0; s < num_sets; s++)
                for (int b = 0; b < 32; b++) model[w][s][b] = 8'h00;
    endtask

    task automatic model_write(input int w, input int s, input logic [31:0] we,
                               input logic [255:0] d);
        for (int b = 0; b < 32; b++)
            if (we[b]) model[w][s][b] = d[8*b +: 8];
    endtask

    function automatic logic [255:0] model_line(input int w, input int s);
        logic [255:0] l;
        for (int b = 0; b < 32; b++) l[8*b +: 8] = model[w][s][b];
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic run_init();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (num_sets) tick();
        model_clear();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready); end
        checks++; if (bus.resp !== 1'b0) begin errors++; $display("FAIL reset_resp got %b want 0", bus.resp); end
        checks++; if (bus.dataout !== '0) begin errors++; $display("FAIL reset_dataout got %h want 0", bus.dataout); end
        rst = 1'b0;
        for (int n = 1; n <= num_sets; n++) begin
            tick();
            checks++;
            if (bus.ready !== (n == num_sets)) begin
                errors++;
                $display("FAIL init_ready edge %0d got %b want %b", n, bus.ready, n == num_sets);
            end
        end
        model_clear();
        // Back-to-back reads of every (way, set).
        for (int w = 0; w < num_ways; w++) begin
            for (int s = 0; s < num_sets; s++) begin
                bus.read = 1'b1; bus.way = w[0]; bus.index = s[2:0];
                tick();
                checks++;
                if (bus.resp !== 1'b1 || bus.dataout !== '0) begin
                    errors++;
                    $display("FAIL init_read w%0d s%0d got resp %b data %h want resp 1 data 0",
                             w, s, bus.resp, bus.dataout);
                end
            end
        end
        idle_inputs();
        tick();
        checks++; if (bus.resp !== 1'b0) begin errors++; $display("FAIL resp_single got %b want 0", bus.resp); end
        last_dout = '0;
    endtask

    task automatic test_write_mask();
        logic [255:0] want;
        bus.write = 1'b1; bus.way = 1'b1; bus.index = 3'd3;
        bus.write_en = 32'h0000_000F; bus.datain = {32{8'hA5}};
        tick();
        model_write(1, 3, 32'h0000_000F, {32{8'hA5}});
        checks++; if (bus.resp !== 1'b0) begin errors++; $display("FAIL write_no_resp got %b want 0", bus.resp); end
        idle_inputs();
        bus.read = 1'b1; bus.way = 1'b1; bus.index = 3'd3;
        tick();
        want = {224'h0, 32'hA5A5_A5A5};
        checks++;
        if (bus.resp !== 1'b1 || bus.dataout !== want) begin
            errors++; $display("FAIL mask_read got %b/%h want 1/%h", bus.resp, bus.dataout, want);
        end
        bus.way = 1'b0;
        tick();
        checks++;
        if (bus.resp !== 1'b1 || bus.dataout !== '0) begin
            errors++; $display("FAIL other_way got %b/%h want 1/0", bus.resp, bus.dataout);
        end
        idle_inputs();
        tick();
        checks++; if (bus.dataout !== '0) begin errors++; $display("FAIL hold got %h want 0", bus.dataout); end
        last_dout = '0;
    endtask

    task automatic test_rw_same_cycle();
        logic [255:0] d;
        d = rand_line();
        d[7:0] = 8'h3C;
        bus.read = 1'b1; bus.write = 1'b1; bus.way = 1'b0; bus.index = 3'd5;
        bus.write_en = 32'h1; bus.datain = d;
        tick();
        model_write(0, 5, 32'h1, d);
        checks++;
        if (bus.resp !== 1'b1 || bus.dataout !== {248'h0, 8'h3C}) begin
            errors++; $display("FAIL write_first got %b/%h want 1/%h", bus.resp, bus.dataout,
                               {248'h0, 8'h3C});
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.resp !== 1'b0 || bus.dataout !== {248'h0, 8'h3C}) begin
            errors++; $display("FAIL write_first_hold got %b/%h", bus.resp, bus.dataout);
        end
        last_dout = model_line(0, 5);
    endtask

    task automatic test_zero_mask();
        logic [255:0] d;
        d = rand_line();
        bus.write = 1'b1; bus.way = 1'b1; bus.index = 3'd2;
        bus.write_en = 32'hFFFF_FFFF; bus.datain = d;
        tick();
        model_write(1, 2, 32'hFFFF_FFFF, d);
        bus.write_en = '0; bus.datain = {32{8'hFF}};
        tick();
        idle_inputs();
        bus.read = 1'b1; bus.way = 1'b1; bus.index = 3'd2;
        tick();
        checks++;
        if (bus.dataout !== model_line(1, 2)) begin
            errors++; $display("FAIL zero_mask got %h want %h", bus.dataout, model_line(1, 2));
        end
        idle_inputs();
        last_dout = model_line(1, 2);
    endtask

    task automatic test_init_ignore();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        bus.read = 1'b1; bus.write = 1'b1; bus.way = 1'b1; bus.index = 3'd0;
        bus.write_en = 32'hFFFF_FFFF; bus.datain = {32{8'hFF}};
        tick();
        idle_inputs();
        checks++; if (bus.resp !== 1'b0) begin errors++; $display("FAIL init_resp got %b want 0", bus.resp); end
        checks++; if (bus.dataout !== '0) begin errors++; $display("FAIL init_dout got %h want 0", bus.dataout); end
        repeat (4) tick();
        model_clear();
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL ready_after_init got %b want 1", bus.ready); end
        bus.read = 1'b1; bus.way = 1'b1; bus.index = 3'd0;
        tick();
        idle_inputs();
        checks++;
        if (bus.resp !== 1'b1 || bus.dataout !== '0) begin
            errors++; $display("FAIL init_write_ignored got %b/%h want 1/0", bus.resp, bus.dataout);
        end
        // Reset pulse at the fourth INIT cycle restarts the sweep.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 1; n <= num_sets; n++) begin
            tick();
            checks++;
            if (bus.ready !== (n == num_sets)) begin
                errors++;
                $display("FAIL restart_ready edge %0d got %b want %b", n, bus.ready, n == num_sets);
            end
        end
        model_clear();
        last_dout = '0;
    endtask

    task automatic test_reset_drop();
        logic [255:0] d;
        d = rand_line();
        bus.write = 1'b1; bus.way = 1'b1; bus.index = 3'd7;
        bus.write_en = 32'hFFFF_FFFF; bus.datain = d;
        tick();
        idle_inputs();
        bus.read = 1'b1; bus.way = 1'b1; bus.index = 3'd7;
        rst = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.resp !== 1'b0 || bus.dataout !== '0 || bus.ready !== 1'b0) begin
            errors++; $display("FAIL reset_drop got resp %b data %h ready %b want 0/0/0",
                               bus.resp, bus.dataout, bus.ready);
        end
        rst = 1'b0;
        repeat (num_sets) tick();
        model_clear();
        bus.read = 1'b1; bus.way = 1'b1; bus.index = 3'd7;
        tick();
        idle_inputs();
        checks++;
        if (bus.resp !== 1'b1 || bus.dataout !== '0) begin
            errors++; $display("FAIL reset_cleared got %b/%h want 1/0", bus.resp, bus.dataout);
        end
        last_dout = '0;
    endtask

    task automatic test_random();
        logic [255:0] want;
        logic [31:0]  we;
        logic [255:0] d;
        logic         r, wr;
        int           w, s;
        for (int it = 0; it < 400; it++) begin
            r  = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, num_ways - 1);
            s  = $urandom_range(0, num_sets - 1);
            case ($urandom_range(0, 3))
                0:       we = '0;
                1:       we = '1;
                default: we = $urandom;
            endcase
            d = rand_line();
            bus.read = r; bus.write = wr; bus.way = w[0]; bus.index = s[2:0];
            bus.write_en = we; bus.datain = d;
            if (wr) model_write(w, s, we, d);
            want = r ? model_line(w, s) : last_dout;
            tick();
            checks++;
            if (bus.resp !== r || bus.dataout !== want) begin
                errors++;
                $display("FAIL random it%0d got %b/%h want %b/%h", it, bus.resp, bus.dataout, r, want);
            end
            last_dout = want;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        model_clear();
        last_dout = '0;
        test_reset();
        test_write_mask();
        test_rw_same_cycle();
        test_zero_mask();
        test_random();
        test_init_ignore();
        test_reset_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
